// File: rtl/wb_loopback_pkg.sv
// Shared constants for the Wishbone loopback responder: register map,
// status register bit positions and the linefeed character.
package wb_loopback_pkg;

  localparam logic [31:0] STATUS_ADDR = 32'h10;
  localparam logic [31:0] RX_ADDR     = 32'h11;
  localparam logic [31:0] TX_ADDR     = 32'h12;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_UNF   = 4;
  localparam int ST_TX_OVF   = 5;

  localparam logic [7:0] LINEFEED = 8'h0A;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_STATUS,
    REG_RX,
    REG_TX
  } reg_sel_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head; push is refused
// when full and pop is ignored when empty, both judged on pre-edge state.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                push_i,
  input  logic [7:0]          data_i,
  input  logic                pop_i,
  output logic [7:0]          head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_loopback_responder.sv
// Wishbone responder mimicking the UART register map: side-port bytes feed
// the RX FIFO, bus writes feed a TX FIFO drained over a valid/ready port.
module wb_loopback_responder
  import wb_loopback_pkg::*;
#(
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter logic [31:0] ADDR_STATUS     = STATUS_ADDR,
  parameter logic [31:0] ADDR_RX         = RX_ADDR,
  parameter logic [31:0] ADDR_TX         = TX_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] wb_data_in,
  output logic [31:0] wb_data_out,
  input  logic [31:0] wb_addr_in,
  input  logic        wb_write_enable_in,
  input  logic        wb_strobe_in,
  output logic        wb_ack_out,
  input  logic [7:0]  i_inj_byte,
  input  logic        i_inj_valid,
  output logic        o_inj_ready,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        rx_fifo_byte_available,
  output logic        rx_linefeed_available
);

  localparam int CW = FIFO_DEPTH_LOG2 + 1;

  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0] rx_count, tx_count;
  logic [7:0]    rx_head;
  logic          rx_push, rx_pop, rx_pop_req, tx_push, tx_push_req, tx_pop;
  logic          bus_rd, bus_wr, lf_in, lf_out;
  reg_sel_e      sel;
  logic [31:0]   status_word;

  logic [31:0]   wb_data_q, wb_data_d;
  logic          wb_ack_q;
  logic          rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;
  logic [CW-1:0] lf_cnt_q, lf_cnt_d;

  logic unused_wdata;
  assign unused_wdata = ^wb_data_in[31:8];

  byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .push_i  (rx_push),
    .data_i  (i_inj_byte),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .push_i  (tx_push),
    .data_i  (wb_data_in[7:0]),
    .pop_i   (tx_pop),
    .head_o  (o_tx_byte),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  always_comb begin
    sel = REG_NONE;
    if      (wb_addr_in == ADDR_STATUS) sel = REG_STATUS;
    else if (wb_addr_in == ADDR_RX)     sel = REG_RX;
    else if (wb_addr_in == ADDR_TX)     sel = REG_TX;
  end

  assign bus_rd      = wb_strobe_in & ~wb_write_enable_in;
  assign bus_wr      = wb_strobe_in & wb_write_enable_in;
  assign rx_pop_req  = bus_rd & (sel == REG_RX);
  assign rx_pop      = rx_pop_req & ~rx_empty;
  assign tx_push_req = bus_wr & (sel == REG_TX);
  assign tx_push     = tx_push_req & ~tx_full;
  assign rx_push     = i_inj_valid & ~rx_full;
  assign tx_pop      = ~tx_empty & i_tx_ready;
  assign lf_in       = rx_push & (i_inj_byte == LINEFEED);
  assign lf_out      = rx_pop & (rx_head == LINEFEED);

  always_comb begin
    status_word              = '0;
    status_word[ST_RX_EMPTY] = rx_empty;
    status_word[ST_RX_FULL]  = rx_full;
    status_word[ST_TX_EMPTY] = tx_empty;
    status_word[ST_TX_FULL]  = tx_full;
    status_word[ST_RX_UNF]   = rx_unf_q;
    status_word[ST_TX_OVF]   = tx_ovf_q;
    status_word[15:8]        = 8'(rx_count);
    status_word[23:16]       = 8'(tx_count);
  end

  always_comb begin
    wb_data_d = wb_data_q;
    rx_unf_d  = rx_unf_q;
    tx_ovf_d  = tx_ovf_q;
    lf_cnt_d  = lf_cnt_q;

    if (bus_rd) begin
      unique case (sel)
        REG_STATUS: wb_data_d = status_word;
        REG_RX:     wb_data_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        default:    wb_data_d = 32'h0;
      endcase
    end

    // Clear first so that a same-cycle set takes precedence.
    if (bus_wr && sel == REG_STATUS) begin
      if (wb_data_in[ST_RX_UNF]) rx_unf_d = 1'b0;
      if (wb_data_in[ST_TX_OVF]) tx_ovf_d = 1'b0;
    end
    if (rx_pop_req && rx_empty) rx_unf_d = 1'b1;
    if (tx_push_req && tx_full) tx_ovf_d = 1'b1;

    unique case ({lf_in, lf_out})
      2'b10:   lf_cnt_d = lf_cnt_q + 1'b1;
      2'b01:   lf_cnt_d = lf_cnt_q - 1'b1;
      default: lf_cnt_d = lf_cnt_q;
    endcase
  end

  // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_data_q <= '0;
      wb_ack_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      lf_cnt_q  <= '0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_ack_q  <= wb_strobe_in;
      rx_unf_q  <= rx_unf_d;
      tx_ovf_q  <= tx_ovf_d;
      lf_cnt_q  <= lf_cnt_d;
    end
  end

  assign wb_data_out            = wb_data_q;
  assign wb_ack_out             = wb_ack_q;
  assign o_inj_ready            = ~rx_full;
  assign o_tx_valid             = ~tx_empty;
  assign rx_fifo_byte_available = ~rx_empty;
  assign rx_linefeed_available  = (lf_cnt_q != '0);

endmodule

// File: tb/tb_wb_loopback_responder.sv
// Directed bench for wb_loopback_responder: inputs change on the falling
// edge, outputs are sampled on the falling edge after the rising edge.
module tb_wb_loopback_responder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] wb_data_in = '0;
  logic [31:0] wb_data_out;
  logic [31:0] wb_addr_in = '0;
  logic        wb_write_enable_in = 1'b0;
  logic        wb_strobe_in = 1'b0;
  logic        wb_ack_out;
  logic [7:0]  i_inj_byte = '0;
  logic        i_inj_valid = 1'b0;
  logic        o_inj_ready;
  logic [7:0]  o_tx_byte;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic        rx_fifo_byte_available;
  logic        rx_linefeed_available;

  int vectors = 0;
  int miscompares = 0;

  wb_loopback_responder dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .wb_data_in             (wb_data_in),
    .wb_data_out            (wb_data_out),
    .wb_addr_in             (wb_addr_in),
    .wb_write_enable_in     (wb_write_enable_in),
    .wb_strobe_in           (wb_strobe_in),
    .wb_ack_out             (wb_ack_out),
    .i_inj_byte             (i_inj_byte),
    .i_inj_valid            (i_inj_valid),
    .o_inj_ready            (o_inj_ready),
    .o_tx_byte              (o_tx_byte),
    .o_tx_valid             (o_tx_valid),
    .i_tx_ready             (i_tx_ready),
    .rx_fifo_byte_available (rx_fifo_byte_available),
    .rx_linefeed_available  (rx_linefeed_available)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; returns on the falling edge where its ack is visible.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    wb_strobe_in       = 1'b1;
    wb_write_enable_in = we;
    wb_addr_in         = addr;
    wb_data_in         = data;
    @(negedge i_clk);
    wb_strobe_in       = 1'b0;
    wb_write_enable_in = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus(1'b0, addr, 32'h0);
    check({tag, "_ack"}, {31'h0, wb_ack_out}, 32'h1);
    check(tag, wb_data_out, exp);
  endtask

  task automatic inject(input logic [7:0] b);
    i_inj_valid = 1'b1;
    i_inj_byte  = b;
    @(negedge i_clk);
    i_inj_valid = 1'b0;
  endtask

  initial begin
    // Reset and idle state
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ack",       {31'h0, wb_ack_out}, 32'h0);
    check("rst_data",      wb_data_out, 32'h0);
    check("rst_inj_ready", {31'h0, o_inj_ready}, 32'h1);
    check("rst_tx_valid",  {31'h0, o_tx_valid}, 32'h0);
    check("rst_byte_avail", {31'h0, rx_fifo_byte_available}, 32'h0);
    check("rst_lf_avail",  {31'h0, rx_linefeed_available}, 32'h0);
    bus_read(32'h10, 32'h0000_0005, "status_after_reset");
    @(negedge i_clk);
    check("ack_single_cycle", {31'h0, wb_ack_out}, 32'h0);
    check("data_holds",       wb_data_out, 32'h0000_0005);

    // Inject and pop with a linefeed
    inject(8'h41);
    check("avail_after_41", {31'h0, rx_fifo_byte_available}, 32'h1);
    check("lf_after_41",    {31'h0, rx_linefeed_available}, 32'h0);
    inject(8'h0A);
    check("lf_after_0a",    {31'h0, rx_linefeed_available}, 32'h1);
    bus_read(32'h11, 32'h0000_0041, "pop_41");
    check("lf_after_pop_41", {31'h0, rx_linefeed_available}, 32'h1);
    bus_read(32'h11, 32'h0000_000A, "pop_0a");
    check("lf_after_pop_0a",    {31'h0, rx_linefeed_available}, 32'h0);
    check("avail_after_pop_0a", {31'h0, rx_fifo_byte_available}, 32'h0);

    // Underflow and sticky clear; other addresses read 0
    bus_read(32'h11, 32'h0, "pop_empty");
    bus_read(32'h10, 32'h0000_0015, "status_underflow");
    bus(1'b1, 32'h10, 32'h10);
    bus_read(32'h10, 32'h0000_0005, "status_unf_cleared");
    bus_read(32'h12, 32'h0, "read_tx_addr");
    bus_read(32'h44, 32'h0, "read_unmapped");

    // TX fill, overflow, drain
    i_tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus(1'b1, 32'h12, 32'(i));
    bus_read(32'h10, 32'h0010_0009, "status_tx_full");
    check("tx_valid_full", {31'h0, o_tx_valid}, 32'h1);
    check("tx_head_full",  {24'h0, o_tx_byte}, 32'h0);
    bus(1'b1, 32'h12, 32'h10);
    bus_read(32'h10, 32'h0010_0029, "status_tx_overflow");
    i_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx_drain_%0d", i), {24'h0, o_tx_byte}, 32'(i));
      @(negedge i_clk);
    end
    check("tx_valid_drained", {31'h0, o_tx_valid}, 32'h0);
    i_tx_ready = 1'b0;
    bus(1'b1, 32'h10, 32'h20);
    bus_read(32'h10, 32'h0000_0005, "status_ovf_cleared");

    // RX full with simultaneous inject and pop
    for (int i = 0; i < 16; i++) inject(8'(32'h20 + i));
    check("inj_ready_full", {31'h0, o_inj_ready}, 32'h0);
    bus_read(32'h10, 32'h0000_1006, "status_rx_full");
    i_inj_valid = 1'b1;
    i_inj_byte  = 8'h55;
    bus(1'b0, 32'h11, 32'h0);
    check("pop_while_full", wb_data_out, 32'h0000_0020);
    check("inj_ready_after_pop", {31'h0, o_inj_ready}, 32'h1);
    bus_read(32'h10, 32'h0000_0F04, "status_count_15");
    i_inj_valid = 1'b0;
    check("inj_ready_refilled", {31'h0, o_inj_ready}, 32'h0);
    bus_read(32'h10, 32'h0000_1006, "status_count_16");
    for (int i = 1; i < 16; i++) bus_read(32'h11, 32'(32'h20 + i), $sformatf("rx_drain_%0d", i));
    bus_read(32'h11, 32'h0000_0055, "rx_drain_last");
    check("avail_rx_drained", {31'h0, rx_fifo_byte_available}, 32'h0);

    // Reset in the middle of traffic
    inject(8'h0A);
    for (int i = 1; i < 5; i++) inject(8'(32'h60 + i));
    for (int i = 0; i < 5; i++) bus(1'b1, 32'h12, 32'(32'hA0 + i));
    bus_read(32'h10, 32'h0005_0500, "status_five_each");
    check("lf_before_reset", {31'h0, rx_linefeed_available}, 32'h1);
    wb_strobe_in = 1'b1;
    wb_addr_in   = 32'h10;
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_ack",       {31'h0, wb_ack_out}, 32'h0);
    check("async_rst_data",      wb_data_out, 32'h0);
    check("async_rst_inj_ready", {31'h0, o_inj_ready}, 32'h1);
    check("async_rst_tx_valid",  {31'h0, o_tx_valid}, 32'h0);
    check("async_rst_avail",     {31'h0, rx_fifo_byte_available}, 32'h0);
    check("async_rst_lf",        {31'h0, rx_linefeed_available}, 32'h0);
    @(negedge i_clk);
    check("rst_no_ack_in_flight", {31'h0, wb_ack_out}, 32'h0);
    wb_strobe_in = 1'b0;
    i_rst_n      = 1'b1;
    @(negedge i_clk);
    bus_read(32'h10, 32'h0000_0005, "status_after_midreset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
